// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator: free-running h/v counters with a stall
// enable, and a registered decode of sync, data-enable, coordinates and
// line/frame start pulses. Outputs lag the counters by exactly one cycle.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned COORD_W   = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               line_start,
  output logic               frame_start
);

  localparam logic [COORD_W-1:0] H_LAST    = COORD_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [COORD_W-1:0] V_LAST    = COORD_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [COORD_W-1:0] H_ACT_END = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT_END = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_START  = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END    = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START  = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END    = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [COORD_W-1:0] h_q, h_d;
  logic [COORD_W-1:0] v_q, v_d;

  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               de_q, de_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               ls_q, ls_d;
  logic               fs_q, fs_d;

  logic               hs_act;
  logic               vs_act;

  // Next counter values: h wraps at end of line, v steps (and wraps) only then.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (enable) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d = '0;
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Decode from the pre-edge counters; hold outputs and suppress pulses while stalled.
  always_comb begin
    hs_act  = (h_q >= HS_START) && (h_q < HS_END);
    vs_act  = (v_q >= VS_START) && (v_q < VS_END);
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    de_d    = de_q;
    x_d     = x_q;
    y_d     = y_q;
    ls_d    = 1'b0;
    fs_d    = 1'b0;
    if (enable) begin
      hsync_d = hs_act ? HSYNC_POL : ~HSYNC_POL;
      vsync_d = vs_act ? VSYNC_POL : ~VSYNC_POL;
      de_d    = (h_q < H_ACT_END) && (v_q < V_ACT_END);
      x_d     = h_q;
      y_d     = v_q;
      ls_d    = (h_q == '0);
      fs_d    = (h_q == '0) && (v_q == '0);
    end
  end

  // Counter and output registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      de_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: instance A uses the full 640x480 timing for reset,
// horizontal and stall checks; instance B keeps the horizontal timing but has
// a 13-line frame (vsync on lines 8..9) so frame, wrap and mid-frame reset
// behaviour fit in a short run.
module tb_vga_timing_gen;

  logic       clk;
  logic       rst_a, en_a, rst_b, en_b;
  logic       hs_a, vs_a, de_a, ls_a, fs_a;
  logic [9:0] x_a, y_a;
  logic       hs_b, vs_b, de_b, ls_b, fs_b;
  logic [9:0] x_b, y_b;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  vga_timing_gen dut_a (
    .clock(clk), .reset(rst_a), .enable(en_a),
    .hsync(hs_a), .vsync(vs_a), .de(de_a), .x(x_a), .y(y_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_b (
    .clock(clk), .reset(rst_b), .enable(en_b),
    .hsync(hs_b), .vsync(vs_b), .de(de_b), .x(x_b), .y(y_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          en;
    int unsigned ncyc;
    int unsigned x;
    int unsigned y;
    bit          de;
    bit          hs;
    bit          vs;
    bit          ls;
    bit          fs;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_a(input vec_t v, input int idx);
    chk($sformatf("v%0d x", idx), x_a, v.x);
    chk($sformatf("v%0d y", idx), y_a, v.y);
    chk($sformatf("v%0d de", idx), de_a, v.de);
    chk($sformatf("v%0d hsync", idx), hs_a, v.hs);
    chk($sformatf("v%0d vsync", idx), vs_a, v.vs);
    chk($sformatf("v%0d line_start", idx), ls_a, v.ls);
    chk($sformatf("v%0d frame_start", idx), fs_a, v.fs);
  endtask

  // Stalled vectors are compared on every cycle, running ones at the end.
  task automatic apply(input int idx);
    vec_t v;
    v = tbl[idx];
    en_a = v.en;
    for (int unsigned k = 0; k < v.ncyc; k++) begin
      @(negedge clk);
      if (!v.en || k == v.ncyc - 1) cmp_a(v, idx);
    end
  endtask

  task automatic chk_reset_b(input string tag);
    chk({tag, " hsync"}, hs_b, 1);
    chk({tag, " vsync"}, vs_b, 1);
    chk({tag, " de"}, de_b, 0);
    chk({tag, " x"}, x_b, 0);
    chk({tag, " y"}, y_b, 0);
    chk({tag, " line_start"}, ls_b, 0);
    chk({tag, " frame_start"}, fs_b, 0);
  endtask

  // Counter range and active-area bounds on every cycle for both instances.
  always @(negedge clk) begin
    n_chk++;
    if (x_a >= 800 || y_a >= 525 || (de_a && (y_a >= 480 || x_a >= 640))) begin
      n_fail++;
      $display("FAIL bounds_a: got x=%0d y=%0d de=%0d, required x<800 y<525 and de only in 640x480", x_a, y_a, de_a);
    end
    n_chk++;
    if (x_b >= 800 || y_b >= 13 || (de_b && (y_b >= 6 || x_b >= 640))) begin
      n_fail++;
      $display("FAIL bounds_b: got x=%0d y=%0d de=%0d, required x<800 y<13 and de only in 640x6", x_b, y_b, de_b);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1);
  end

  initial begin
    int unsigned de_cnt, hs_cnt, hs_first, ls_extra;
    int unsigned cyc, vs_cnt, vs_fx, vs_fy, bad_de, wraps;
    int unsigned px, py;
    bit          found, vs_seen, hs_seen;

    //            en  ncyc   x    y  de hs vs ls fs
    tbl[0]  = '{1'b1,    1,   0,   0, 1, 1, 1, 1, 1};
    tbl[1]  = '{1'b1,    1,   1,   0, 1, 1, 1, 0, 0};
    tbl[2]  = '{1'b1,  638, 639,   0, 1, 1, 1, 0, 0};
    tbl[3]  = '{1'b1,    1, 640,   0, 0, 1, 1, 0, 0};
    tbl[4]  = '{1'b1,   16, 656,   0, 0, 0, 1, 0, 0};
    tbl[5]  = '{1'b1,   95, 751,   0, 0, 0, 1, 0, 0};
    tbl[6]  = '{1'b1,    1, 752,   0, 0, 1, 1, 0, 0};
    tbl[7]  = '{1'b1,   47, 799,   0, 0, 1, 1, 0, 0};
    tbl[8]  = '{1'b1,    1,   0,   1, 1, 1, 1, 1, 0};
    tbl[9]  = '{1'b1, 2500, 100,   5, 1, 1, 1, 0, 0};
    tbl[10] = '{1'b0,   37, 100,   5, 1, 1, 1, 0, 0};
    tbl[11] = '{1'b1,    1, 101,   5, 1, 1, 1, 0, 0};
    tbl[12] = '{1'b1,  698, 799,   5, 0, 1, 1, 0, 0};
    tbl[13] = '{1'b1,    1,   0,   6, 1, 1, 1, 1, 0};
    tbl[14] = '{1'b0,    1,   0,   6, 1, 1, 1, 0, 0};
    tbl[15] = '{1'b1,    1,   1,   6, 1, 1, 1, 0, 0};

    rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b1; en_b = 1'b1;
    #1;
    rst_a = 1'b1; rst_b = 1'b1;

    // Reset held for 10 cycles with enable high: outputs stay at reset values.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst hsync", hs_a, 1);
      chk("rst vsync", vs_a, 1);
      chk("rst de", de_a, 0);
      chk("rst x", x_a, 0);
      chk("rst y", y_a, 0);
      chk("rst line_start", ls_a, 0);
      chk("rst frame_start", fs_a, 0);
    end
    rst_a = 1'b0;

    for (int i = 0; i <= 8; i++) apply(i);

    // One full line measured from the line_start just observed.
    de_cnt = 0; hs_cnt = 0; hs_first = 0; ls_extra = 0; hs_seen = 0;
    for (int unsigned k = 0; k < 800; k++) begin
      if (de_a) de_cnt++;
      if (!hs_a) begin
        if (!hs_seen) hs_first = k;
        hs_seen = 1;
        hs_cnt++;
      end
      if (k != 0 && ls_a) ls_extra++;
      @(negedge clk);
    end
    chk("line de cycles", de_cnt, 640);
    chk("line hsync cycles", hs_cnt, 96);
    chk("line hsync offset", hs_first, 656);
    chk("line extra line_start", ls_extra, 0);
    chk("line next line_start", ls_a, 1);
    chk("line next y", y_a, 2);

    for (int i = 9; i <= 15; i++) apply(i);

    // Instance B: full frame, vsync placement, wrap to frame_start.
    chk_reset_b("rstB");
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    chk("B first frame_start", fs_b, 1);
    chk("B first de", de_b, 1);
    chk("B first x", x_b, 0);
    chk("B first y", y_b, 0);

    cyc = 0; vs_cnt = 0; vs_fx = 0; vs_fy = 0; bad_de = 0; wraps = 0;
    found = 0; vs_seen = 0; px = x_b; py = y_b;
    while (!found && cyc < 12000) begin
      @(negedge clk);
      cyc++;
      if (!vs_b) begin
        if (!vs_seen) begin
          vs_fx = x_b;
          vs_fy = y_b;
        end
        vs_seen = 1;
        vs_cnt++;
      end
      if (de_b && y_b >= 6) bad_de++;
      if (px == 799 && py == 12) begin
        wraps++;
        chk("B wrap x", x_b, 0);
        chk("B wrap y", y_b, 0);
        chk("B wrap frame_start", fs_b, 1);
      end
      px = x_b;
      py = y_b;
      if (fs_b) found = 1;
    end
    chk("B frame_start seen", found, 1);
    chk("B frame period", cyc, 10400);
    chk("B vsync cycles", vs_cnt, 1600);
    chk("B vsync first x", vs_fx, 0);
    chk("B vsync first y", vs_fy, 8);
    chk("B de outside active lines", bad_de, 0);
    chk("B wrap observed", wraps, 1);

    // Move to x=700, y=9 with both syncs active, then reset between edges.
    repeat (7900) @(negedge clk);
    chk("B pre-reset x", x_b, 700);
    chk("B pre-reset y", y_b, 9);
    chk("B pre-reset hsync", hs_b, 0);
    chk("B pre-reset vsync", vs_b, 0);
    #2;
    rst_b = 1'b1;
    #1;
    chk_reset_b("asyncB");
    repeat (2) @(negedge clk);
    chk_reset_b("heldB");
    rst_b = 1'b0;
    @(negedge clk);
    chk("B restart frame_start", fs_b, 1);
    chk("B restart line_start", ls_b, 1);
    chk("B restart de", de_b, 1);
    chk("B restart x", x_b, 0);
    chk("B restart y", y_b, 0);
    @(negedge clk);
    chk("B restart+1 x", x_b, 1);
    chk("B restart+1 frame_start", fs_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
